bus_arbiter: RTL and testbench



---
 rtl/bus_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 29 ++
 rtl/bus_arbiter.sv | 129 ++++++++++++
 tb/tb_bus_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
// Optional build macro used by this slice: BUS_ARB_PRIO0_EN.
package bus_arb_pkg;

  localparam int NUM_REQ_DEF = 32;
  localparam int SEL_W_DEF   = 5;

  // owner_cnt is a small saturating debug counter
  localparam int                 CNT_W   = 3;
  localparam logic [CNT_W-1:0]   CNT_MAX = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: finds the first set request scanning upward
// from (last+1) mod NUM_REQ and wrapping around. Purely combinational.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int SEL_W   = SEL_W_DEF
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   winner
);

  logic [SEL_W-1:0] idx_s;

  // Scan offsets from farthest to nearest so the nearest requester wins
  always_comb begin
    any    = 1'b0;
    winner = {SEL_W{1'b0}};
    idx_s  = {SEL_W{1'b0}};
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx_s  = SEL_W'((int'(last) + k) % NUM_REQ);
      winner = req[idx_s] ? idx_s : winner;
      any    = any | req[idx_s];
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the CPU internal bus: one-hot grant, mux select,
// bounded hold time per owner and a one-cycle turnaround between owners.
// Optional build macro: BUS_ARB_PRIO0_EN (source 0 always wins arbitration
// and does not move the rotation pointer when it releases).
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int MAX_HOLD = 4
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   select,
  output logic               bus_valid,
  output logic [CNT_W-1:0]   owner_cnt
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   select_q, select_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   last_q, last_d;

  logic               pick_any_s;
  logic [SEL_W-1:0]   pick_win_s;
  logic [SEL_W-1:0]   winner_s;
  logic               owner_req_s;
  logic               hold_ok_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic [SEL_W-1:0]   release_last_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_rr_pick (
    .req     (req),
    .last    (last_q),
    .any     (pick_any_s),
    .winner  (pick_win_s)
  );

  // Winner selection, hold-limit test and rotation pointer update on release
  always_comb begin
    owner_req_s = req[select_q];
    hold_ok_s   = (MAX_HOLD == 0) || (int'(cnt_q) < MAX_HOLD);
    cnt_inc_s   = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_W'(1));
`ifdef BUS_ARB_PRIO0_EN
    // Source 0 (PC) beats the rotation and leaves the pointer untouched
    winner_s       = req[0] ? {SEL_W{1'b0}} : pick_win_s;
    release_last_s = (select_q == {SEL_W{1'b0}}) ? last_q : select_q;
`else
    winner_s       = pick_win_s;
    release_last_s = select_q;
`endif
  end

  // Next-state and registered-output logic of the arbitration FSM
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    select_d = select_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    case (state_q)
      IDLE, TURN: begin
        if (pick_any_s) begin
          state_d  = GRANT;
          grant_d  = NUM_REQ'(1) << winner_s;
          select_d = winner_s;
          valid_d  = 1'b1;
          cnt_d    = CNT_W'(1);
        end else begin
          // select keeps the last owner so the mux input does not glitch
          state_d = IDLE;
          grant_d = {NUM_REQ{1'b0}};
          valid_d = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      GRANT: begin
        if (owner_req_s && hold_ok_s) begin
          cnt_d = cnt_inc_s;
        end else begin
          state_d = TURN;
          grant_d = {NUM_REQ{1'b0}};
          valid_d = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
          last_d  = release_last_s;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = {NUM_REQ{1'b0}};
        valid_d = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers, cleared asynchronously by clear_n
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= IDLE;
      grant_q  <= {NUM_REQ{1'b0}};
      select_q <= {SEL_W{1'b0}};
      valid_q  <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      last_q   <= SEL_W'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  assign grant     = grant_q;
  assign select    = select_q;
  assign bus_valid = valid_q;
  assign owner_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_bus_arbiter;

  localparam int N  = 32;
  localparam int MH = 4;

  logic        clock;
  logic        clear_n;
  logic [31:0] req;
  logic [31:0] grant;
  logic [4:0]  select;
  logic        bus_valid;
  logic [2:0]  owner_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: current owner (-1 = bus free), hold count, pointer
  int m_owner;
  int m_cnt;
  int m_last;
  int m_sel;

  typedef struct {
    logic [31:0] r;
    logic [31:0] g;
    logic [4:0]  s;
    logic        v;
    logic [2:0]  c;
  } vec_t;

  vec_t tbl[$];

  bus_arbiter #(.NUM_REQ(N), .SEL_W(5), .MAX_HOLD(MH)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .req       (req),
    .grant     (grant),
    .select    (select),
    .bus_valid (bus_valid),
    .owner_cnt (owner_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = N - 1;
    m_sel   = 0;
  endfunction

  // One clock of the arbiter rules, applied to the request word sampled at the edge
  function automatic void model_clock(input logic [31:0] r);
    int w;
    if (m_owner >= 0) begin
      if (r[m_owner] && (MH == 0 || m_cnt < MH)) begin
        m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
      end else begin
`ifdef BUS_ARB_PRIO0_EN
        if (m_owner != 0) m_last = m_owner;
`else
        m_last = m_owner;
`endif
        m_owner = -1;
        m_cnt   = 0;
      end
    end else begin
      w = -1;
`ifdef BUS_ARB_PRIO0_EN
      if (r[0]) w = 0;
`endif
      for (int k = 1; k <= N; k++) begin
        if (w < 0 && r[(m_last + k) % N]) w = (m_last + k) % N;
      end
      if (w >= 0) begin
        m_owner = w;
        m_sel   = w;
        m_cnt   = 1;
      end
    end
  endfunction

  task automatic check_model(input string tag);
    logic [31:0] eg;
    eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    check({tag, "_grant"}, grant, eg);
    check({tag, "_select"}, {27'd0, select}, m_sel);
    check({tag, "_valid"}, {31'd0, bus_valid}, {31'd0, (m_owner >= 0)});
    if (m_owner >= 0) check({tag, "_cnt"}, {29'd0, owner_cnt}, m_cnt);
    check({tag, "_onehot"}, {31'd0, $onehot0(grant)}, 32'd1);
    check({tag, "_valid_or"}, {31'd0, bus_valid}, {31'd0, |grant});
  endtask

  // Drive a request word, let one edge sample it, advance the model
  task automatic step(input logic [31:0] r);
    req = r;
    @(posedge clock);
    model_clock(r);
    #1;
  endtask

  initial begin
    int run_len;
    int exp_next;
    logic prev_valid;
    logic [31:0] r;

    clear_n = 1'b0;
    req     = 32'd0;
    model_reset();
    #12;
    check("rst_grant", grant, 32'd0);
    check("rst_select", {27'd0, select}, 32'd0);
    check("rst_valid", {31'd0, bus_valid}, 32'd0);
    check("rst_cnt", {29'd0, owner_cnt}, 32'd0);
    clear_n = 1'b1;

    // Directed vectors: single request, owner-5/req-9 handover, pointer at 10
    tbl.push_back('{32'h0000_0004, 32'h0000_0004, 5'd2,  1'b1, 3'd1});
    tbl.push_back('{32'h0000_0004, 32'h0000_0004, 5'd2,  1'b1, 3'd2});
    tbl.push_back('{32'h0000_0000, 32'h0000_0000, 5'd2,  1'b0, 3'd0});
    tbl.push_back('{32'h0000_0000, 32'h0000_0000, 5'd2,  1'b0, 3'd0});
    tbl.push_back('{32'h0000_0020, 32'h0000_0020, 5'd5,  1'b1, 3'd1});
    tbl.push_back('{32'h0000_0220, 32'h0000_0020, 5'd5,  1'b1, 3'd2});
    tbl.push_back('{32'h0000_0200, 32'h0000_0000, 5'd5,  1'b0, 3'd0});
    tbl.push_back('{32'h0000_0200, 32'h0000_0200, 5'd9,  1'b1, 3'd1});
    tbl.push_back('{32'h0000_0000, 32'h0000_0000, 5'd9,  1'b0, 3'd0});
    tbl.push_back('{32'h0000_0400, 32'h0000_0400, 5'd10, 1'b1, 3'd1});
    tbl.push_back('{32'h0000_0000, 32'h0000_0000, 5'd10, 1'b0, 3'd0});
`ifdef BUS_ARB_PRIO0_EN
    tbl.push_back('{32'h0000_0801, 32'h0000_0001, 5'd0,  1'b1, 3'd1});
    tbl.push_back('{32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0, 3'd0});
`else
    tbl.push_back('{32'h0000_0801, 32'h0000_0800, 5'd11, 1'b1, 3'd1});
    tbl.push_back('{32'h0000_0000, 32'h0000_0000, 5'd11, 1'b0, 3'd0});
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r);
      check($sformatf("vec%0d_grant", i), grant, tbl[i].g);
      check($sformatf("vec%0d_select", i), {27'd0, select}, {27'd0, tbl[i].s});
      check($sformatf("vec%0d_valid", i), {31'd0, bus_valid}, {31'd0, tbl[i].v});
      if (tbl[i].v) check($sformatf("vec%0d_cnt", i), {29'd0, owner_cnt}, {29'd0, tbl[i].c});
    end
    step(32'd0);
    check_model("idle");

    // Lone requester 31: four cycles on, one off, select never moves
    for (int k = 1; k <= 12; k++) begin
      step(32'h8000_0000);
      check_model("single");
      check("single_sel", {27'd0, select}, 32'd31);
      check("single_on", {31'd0, bus_valid}, {31'd0, ((k % 5) != 0)});
    end
    step(32'd0);
    step(32'd0);
    check_model("single_end");

    // Everyone requesting: strict rotation from 0, MH-cycle holds, 1-cycle gaps
    exp_next   = 0;
    run_len    = 0;
    prev_valid = 1'b0;
    for (int k = 0; k < 5 * N + 3; k++) begin
      step(32'hFFFF_FFFF);
      check_model("all");
      if (bus_valid && !prev_valid) begin
        check("all_rotate", grant, 32'd1 << exp_next);
        exp_next = (exp_next + 1) % N;
      end
      if (!bus_valid && prev_valid) check("all_hold_len", run_len, MH);
      run_len    = bus_valid ? run_len + 1 : 0;
      prev_valid = bus_valid;
    end
    step(32'd0);
    step(32'd0);
    check_model("all_end");

    // Asynchronous clear in the middle of a grant to source 7
    step(32'h0000_0080);
    step(32'h0000_0080);
    check_model("pre_clr");
    #2;
    clear_n = 1'b0;
    #1;
    model_reset();
    check("clr_grant", grant, 32'd0);
    check("clr_valid", {31'd0, bus_valid}, 32'd0);
    check("clr_select", {27'd0, select}, 32'd0);
    req = 32'h0000_0008;
    #2;
    clear_n = 1'b1;
    step(32'h0000_0008);
    check("post_clr_grant", grant, 32'h0000_0008);
    check("post_clr_select", {27'd0, select}, 32'd3);
    check_model("post_clr");
    step(32'd0);
    step(32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      r = $urandom() & $urandom() & $urandom();
      if ($urandom_range(0, 7) == 0) r = 32'd0;
      if ($urandom_range(0, 15) == 0) r = 32'hFFFF_FFFF;
      step(r);
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
